fcs_frame_sequencer: RTL and testbench

//  Sequences the 8-bit parallel CRC-32 (IEEE 802.3) engine across whole frames on a byte stream.
//  TX mode: passes payload through, then appends the 4 FCS bytes unloaded from the engine.
//  RX mode: passes all bytes (FCS included) through and reports good/bad CRC plus length status.

---
 rtl/fcs_frame_sequencer_pkg.sv | 23 ++
 rtl/fcs_frame_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fcs_frame_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcs_frame_sequencer_pkg.sv
// Shared definitions for the CRC-32 frame sequencer: state encoding,
// CRC-32 constants and the 802.3 frame length limits.
package fcs_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FCS   = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam int unsigned ETH_MIN_LEN = 64;
  localparam int unsigned ETH_MAX_LEN = 1518;
  localparam int unsigned ETH_LEN_W   = 16;

  localparam int unsigned FCS_BYTES = 4;
  localparam int unsigned FCS_IDX_W = 2;

endpackage

// File: rtl/fcs_frame_sequencer.sv
// Frame sequencer for an external byte-wide CRC-32 engine: appends the FCS in
// TX mode, checks it in RX mode, and reports per-frame length/CRC status.
module fcs_frame_sequencer
  import fcs_frame_sequencer_pkg::*;
#(
  parameter int unsigned MIN_LEN = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN = ETH_MAX_LEN,
  parameter int unsigned LEN_W   = ETH_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             crc_clken,
  output logic             crc_reset,
  output logic             crc_load,
  output logic             crc_compute,
  output logic [7:0]       crc_din,
  input  logic [7:0]       crc_dout,
  input  logic             crc_ok,
  output logic             stat_valid,
  output logic             stat_crc_ok,
  output logic             stat_len_err,
  output logic             stat_abort,
  output logic [LEN_W-1:0] stat_len
);

  localparam logic [LEN_W-1:0]     LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]     LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]     LEN_SAT  = {LEN_W{1'b1}};
  localparam logic [FCS_IDX_W-1:0] IDX_LAST = FCS_IDX_W'(FCS_BYTES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_mode;
  logic [LEN_W-1:0]       r_cnt;
  logic [FCS_IDX_W-1:0]   r_idx;
  logic                   r_stat_valid;
  logic                   r_stat_crc_ok;
  logic                   r_stat_len_err;
  logic                   r_stat_abort;
  logic [LEN_W-1:0]       r_stat_len;

  logic                   w_sof_seen;
  logic                   w_abort;
  logic                   w_data_acc;
  logic                   w_fcs_acc;
  logic                   w_fcs_done;
  logic                   w_frame_end;
  logic [LEN_W-1:0]       w_cnt_inc;
  logic [LEN_W-1:0]       w_final_len;
  logic                   w_len_err;

  // A sof inside a frame (after its first byte) aborts it and is held for the next INIT.
  assign w_sof_seen  = (r_state == ST_IDLE) && in_valid && in_sof;
  assign w_abort     = (r_state == ST_DATA) && in_valid && in_sof && (r_cnt != '0);
  assign w_data_acc  = (r_state == ST_DATA) && in_valid && out_ready && !w_abort;
  assign w_fcs_acc   = (r_state == ST_FCS) && out_ready;
  assign w_fcs_done  = w_fcs_acc && (r_idx == IDX_LAST);
  assign w_frame_end = w_fcs_done || (r_state == ST_CHECK) || w_abort;

  assign w_cnt_inc   = (r_cnt == LEN_SAT) ? r_cnt : r_cnt + LEN_W'(1);
  assign w_final_len = (r_state == ST_FCS) ? w_cnt_inc : r_cnt;
  assign w_len_err   = (w_final_len < LEN_MIN) || (w_final_len > LEN_MAX) ||
                       (w_final_len == LEN_SAT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sof_seen) w_state_nxt = ST_INIT;
      ST_INIT:  w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_abort) begin
          w_state_nxt = ST_INIT;
        end else if (w_data_acc && in_eof) begin
          w_state_nxt = r_mode ? ST_CHECK : ST_FCS;
        end
      end
      ST_FCS:   if (w_fcs_done) w_state_nxt = ST_IDLE;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Stream handshake and CRC engine controls
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_last    = 1'b0;
    crc_clken   = 1'b0;
    crc_reset   = 1'b0;
    crc_load    = 1'b0;
    crc_compute = 1'b0;
    crc_din     = 8'h00;
    case (r_state)
      ST_INIT: begin
        crc_clken = 1'b1;
        crc_reset = 1'b1;
      end
      ST_DATA: begin
        if (!w_abort) begin
          in_ready  = out_ready;
          out_valid = in_valid;
          out_data  = in_data;
          out_last  = r_mode && in_eof;
        end
        if (w_data_acc) begin
          crc_clken   = 1'b1;
          crc_compute = 1'b1;
          crc_din     = in_data;
        end
      end
      ST_FCS: begin
        out_valid = 1'b1;
        out_data  = crc_dout;
        out_last  = (r_idx == IDX_LAST);
        if (out_ready) begin
          crc_clken = 1'b1;
          crc_load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame counter, FCS index, latched mode and end-of-frame status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode         <= 1'b0;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_stat_valid   <= 1'b0;
      r_stat_crc_ok  <= 1'b0;
      r_stat_len_err <= 1'b0;
      r_stat_abort   <= 1'b0;
      r_stat_len     <= '0;
    end else begin
      r_stat_valid <= w_frame_end;
      if (w_sof_seen || w_abort) begin
        r_mode <= mode;
      end
      if (r_state == ST_INIT) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else begin
        if (w_data_acc || w_fcs_acc) r_cnt <= w_cnt_inc;
        if (w_fcs_acc)               r_idx <= r_idx + FCS_IDX_W'(1);
      end
      if (w_frame_end) begin
        r_stat_crc_ok  <= r_mode ? ((r_state == ST_CHECK) && crc_ok) : 1'b1;
        r_stat_len_err <= w_len_err;
        r_stat_abort   <= w_abort;
        r_stat_len     <= w_final_len;
      end
    end
  end

  assign stat_valid   = r_stat_valid;
  assign stat_crc_ok  = r_stat_crc_ok;
  assign stat_len_err = r_stat_len_err;
  assign stat_abort   = r_stat_abort;
  assign stat_len     = r_stat_len;

endmodule

// File: tb/tb_fcs_frame_sequencer.sv
// Bench for fcs_frame_sequencer with a behavioural CRC-32 engine beside it and
// a bit-serial CRC-32 golden model feeding byte and status scoreboards.
module tb_fcs_frame_sequencer;

  localparam logic [31:0] POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] INITV   = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

  typedef struct packed {
    logic        crc_ok;
    logic        len_err;
    logic        abort;
    logic [15:0] len;
  } st_t;

  logic        clk, reset_n, mode;
  logic        in_valid, in_ready, in_sof, in_eof;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        crc_clken, crc_reset, crc_load, crc_compute, crc_ok;
  logic [7:0]  crc_din, crc_dout;
  logic        stat_valid, stat_crc_ok, stat_len_err, stat_abort;
  logic [15:0] stat_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  st_t        stat_q[$];
  logic [7:0] pay[$];
  logic [7:0] tx1[$];

  fcs_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .crc_clken(crc_clken), .crc_reset(crc_reset), .crc_load(crc_load),
    .crc_compute(crc_compute), .crc_din(crc_din), .crc_dout(crc_dout), .crc_ok(crc_ok),
    .stat_valid(stat_valid), .stat_crc_ok(stat_crc_ok), .stat_len_err(stat_len_err),
    .stat_abort(stat_abort), .stat_len(stat_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = INITV;
    foreach (q[i]) c = crc8(c, q[i]);
    return c;
  endfunction

  // Behavioural CRC engine
  logic [31:0] eng;
  always @(posedge clk) begin
    if (crc_clken) begin
      if (crc_reset)        eng <= INITV;
      else if (crc_compute) eng <= crc8(eng, crc_din);
      else if (crc_load)    eng <= {eng[23:0], crc_din};
    end
  end
  assign crc_dout = ~eng[31:23+1];
  assign crc_ok   = (eng == RESIDUE);

  // Output, stall-stability, engine-control and status monitor
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if ((int'(crc_reset) + int'(crc_load) + int'(crc_compute) > 1) ||
          (!crc_clken && (crc_reset || crc_load || crc_compute))) begin
        errors++;
        $display("FAIL crc_ctrl clken=%b reset=%b load=%b compute=%b", crc_clken, crc_reset, crc_load, crc_compute);
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (crc_clken) begin
          errors++;
          $display("FAIL stall_clken engine clocked while output stalled");
        end
      end
      if (prev_stall && out_valid) begin
        checks++;
        if (out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_stable got %02h want %02h", out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_byte unexpected %02h", out_data);
        end else begin
          logic [7:0] ed;
          logic       el;
          ed = exp_q.pop_front();
          el = exp_last_q.pop_front();
          if (out_data !== ed || out_last !== el) begin
            errors++;
            $display("FAIL out_byte got %02h/last %b want %02h/last %b", out_data, out_last, ed, el);
          end
        end
      end
      if (stat_valid) begin
        checks++;
        if (stat_q.size() == 0) begin
          errors++;
          $display("FAIL status unexpected pulse");
        end else begin
          st_t es;
          st_t gs;
          es = stat_q.pop_front();
          gs = {stat_crc_ok, stat_len_err, stat_abort, stat_len};
          if (gs !== es) begin
            errors++;
            $display("FAIL status got ok=%b lerr=%b ab=%b len=%0d want ok=%b lerr=%b ab=%b len=%0d",
                     gs.crc_ok, gs.len_err, gs.abort, gs.len, es.crc_ok, es.len_err, es.abort, es.len);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic m);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof; mode = m;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 4000) begin
        checks++; errors++;
        $display("FAIL send_byte timeout waiting for in_ready");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic send_frame(input logic m, input logic with_eof);
    for (int i = 0; i < pay.size(); i++)
      send_byte(pay[i], i == 0, with_eof && (i == pay.size() - 1), m);
  endtask

  task automatic push_pass(input logic with_last);
    foreach (pay[i]) begin
      exp_q.push_back(pay[i]);
      exp_last_q.push_back(with_last && (i == pay.size() - 1));
    end
  endtask

  task automatic push_tx(output logic [7:0] full[$]);
    logic [31:0] c;
    c = crc_of(pay);
    full = pay;
    push_pass(1'b0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = ~c[31 - 8*k -: 8];
      full.push_back(b);
      exp_q.push_back(b);
      exp_last_q.push_back(k == 3);
    end
  endtask

  function automatic st_t rx_stat(input logic [7:0] q[$]);
    st_t s;
    s.crc_ok  = (crc_of(q) == RESIDUE);
    s.len_err = (q.size() < 64) || (q.size() > 1518);
    s.abort   = 1'b0;
    s.len     = 16'(q.size());
    return s;
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding bytes %0d status %0d want 0 0", exp_q.size(), stat_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] v;
    v = {in_ready, out_valid, out_data, out_last, crc_clken, crc_reset, crc_load, crc_compute,
         crc_din, stat_valid, stat_crc_ok, stat_len_err, stat_abort, stat_len};
    checks++;
    if (v !== 64'h0) begin
      errors++;
      $display("FAIL %s outputs got %h want 0", name, v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b0; in_data = 8'h5A;
    mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    in_sof = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || crc_clken !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_sof in_ready=%b clken=%b want 0 0", in_ready, crc_clken);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_tx();
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    push_tx(tx1);
    stat_q.push_back('{crc_ok: 1'b1, len_err: 1'b0, abort: 1'b0, len: 16'd64});
    send_frame(1'b0, 1'b1);
    wait_done();
  endtask

  task automatic test_loopback();
    pay = tx1;
    push_pass(1'b1);
    stat_q.push_back('{crc_ok: 1'b1, len_err: 1'b0, abort: 1'b0, len: 16'd64});
    send_frame(1'b1, 1'b1);
    wait_done();
    pay[10] = pay[10] ^ 8'h01;
    push_pass(1'b1);
    stat_q.push_back('{crc_ok: 1'b0, len_err: 1'b0, abort: 1'b0, len: 16'd64});
    send_frame(1'b1, 1'b1);
    wait_done();
  endtask

  task automatic test_tx_stall();
    logic [7:0] full[$];
    logic       done;
    done = 1'b0;
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    push_tx(full);
    checks++;
    if (full != tx1) begin
      errors++;
      $display("FAIL stall_model reference frame differs from first TX frame");
    end
    stat_q.push_back('{crc_ok: 1'b1, len_err: 1'b0, abort: 1'b0, len: 16'd64});
    fork
      begin
        send_frame(1'b0, 1'b1);
        wait_done();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    int gap, inits, n;
    for (int i = 0; i < 20; i++)   f1.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 1520; i++) f2.push_back(8'($urandom_range(0, 255)));
    pay = f1; push_pass(1'b1); stat_q.push_back(rx_stat(f1));
    pay = f2; push_pass(1'b1); stat_q.push_back(rx_stat(f2));
    gap = 0; inits = 0;
    fork
      begin
        pay = f1; send_frame(1'b1, 1'b1);
        pay = f2; send_frame(1'b1, 1'b1);
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!stat_valid && n < 200);
        n = 0;
        do begin
          @(negedge clk);
          gap++;
          if (crc_reset) inits++;
          n++;
        end while (!(in_valid && in_ready && in_sof) && n < 50);
      end
    join
    checks++;
    if (inits !== 1 || gap !== 2) begin
      errors++;
      $display("FAIL b2b_gap init_cycles=%0d cycles_to_sof=%0d want 1 2", inits, gap);
    end
    wait_done();
  endtask

  task automatic test_abort();
    pay.delete();
    for (int i = 0; i < 30; i++) pay.push_back(8'($urandom_range(0, 255)));
    push_pass(1'b0);
    stat_q.push_back('{crc_ok: 1'b0, len_err: 1'b1, abort: 1'b1, len: 16'd30});
    send_frame(1'b1, 1'b0);
    pay = tx1;
    push_pass(1'b1);
    stat_q.push_back('{crc_ok: 1'b1, len_err: 1'b0, abort: 1'b0, len: 16'd64});
    send_frame(1'b1, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid_fcs();
    logic [7:0] full[$];
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(8'hA0 + i));
    push_tx(full);
    send_frame(1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== full[62]) begin
      errors++;
      $display("FAIL fcs_idx2 got valid=%b data=%02h want 1 %02h", out_valid, out_data, full[62]);
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_fcs");
    exp_q.delete(); exp_last_q.delete(); stat_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pay.delete();
    for (int i = 0; i < 70; i++) pay.push_back(8'($urandom_range(0, 255)));
    push_tx(full);
    stat_q.push_back('{crc_ok: 1'b1, len_err: 1'b0, abort: 1'b0, len: 16'd74});
    send_frame(1'b0, 1'b1);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tx();
    test_loopback();
    test_tx_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid_fcs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
